mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_if.sv | 12 +
 rtl/mem_stage.sv | 72 +++++++
 tb/tb_mem_stage.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory request/response bus between the MEM stage and memory.
interface mem_stage_if;
    logic [29:0] dmem_addr;
    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    modport master (output dmem_addr, dmem_req, dmem_we, dmem_be, dmem_wdata, input dmem_rdata, dmem_ack);
    modport slave  (input dmem_addr, dmem_req, dmem_we, dmem_be, dmem_wdata, output dmem_rdata, dmem_ack);
endinterface

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage with big-endian byte/half/word access, stall, timeout and sticky error.
module mem_stage #(
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       Result,
    input  logic [31:0]       mem_data_ex,
    input  logic [5:0]        opcode_ex,
    input  logic              MemWrite_ex,
    input  logic              MemtoReg_ex,
    input  logic              RegWrite_ex,
    input  logic [4:0]        towrite_ex,
    mem_stage_if.master       bus,
    output logic [31:0]       result_mem,
    output logic [4:0]        towrite_mem,
    output logic              RegWrite_mem,
    output logic              mem_stall,
    output logic              mem_error
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    typedef enum logic {IDLE, ACCESS} state_t;
    state_t state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0] off;
    logic half, word, sext, mem_op, misaligned, start, done, timeout, err_set, rw_nxt;
    logic [31:0] rshift, load_data, res_nxt;
    always_comb begin
        off = Result[1:0];
        half = opcode_ex[1:0] == 2'b01;
        word = opcode_ex[1:0] == 2'b11;
        sext = opcode_ex[5:2] == 4'b1000;
        mem_op = MemtoReg_ex | MemWrite_ex;
        misaligned = (half & off[0]) | (word & |off);
        start = state == IDLE & mem_op & !misaligned;
        done = state == ACCESS & bus.dmem_ack;
        timeout = state == ACCESS & !bus.dmem_ack & cnt == CW'(MAX_WAIT - 1);
        err_set = (state == IDLE & mem_op & misaligned) | timeout;
        bus.dmem_addr = Result[31:2];
        bus.dmem_req = state == ACCESS;
        bus.dmem_we = state == ACCESS & MemWrite_ex;
        bus.dmem_be = word ? 4'b1111 : half ? (off[1] ? 4'b0011 : 4'b1100) : 4'b1000 >> off;
        bus.dmem_wdata = word ? mem_data_ex : half ? {2{mem_data_ex[15:0]}} : {4{mem_data_ex[7:0]}};
        // Left-align the addressed lane so the wanted bytes always sit at the top.
        rshift = bus.dmem_rdata << {off, 3'b000};
        load_data = word ? rshift :
                    half ? {{16{sext & rshift[31]}}, rshift[31:16]} :
                           {{24{sext & rshift[31]}}, rshift[31:24]};
        state_nxt = state == IDLE ? (start ? ACCESS : IDLE) : ((done | timeout) ? IDLE : ACCESS);
        cnt_nxt = state == ACCESS ? cnt + 1'b1 : '0;
        mem_stall = rst_n & (start | (state == ACCESS & !done & !timeout));
        res_nxt = (done & MemtoReg_ex) ? load_data : Result;
        rw_nxt = state == IDLE ? RegWrite_ex & !mem_op : done & RegWrite_ex & MemtoReg_ex;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            result_mem <= '0;
            towrite_mem <= '0;
            RegWrite_mem <= 1'b0;
            mem_error <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt <= cnt_nxt;
            result_mem <= res_nxt;
            towrite_mem <= towrite_ex;
            RegWrite_mem <= rw_nxt;
            mem_error <= mem_error | err_set;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
module tb_mem_stage;
    logic clk = 1'b0;
    logic rst_n;
    logic [31:0] Result, mem_data_ex;
    logic [5:0] opcode_ex;
    logic MemWrite_ex, MemtoReg_ex, RegWrite_ex;
    logic [4:0] towrite_ex;
    logic [31:0] result_mem;
    logic [4:0] towrite_mem;
    logic RegWrite_mem, mem_stall, mem_error;
    int total = 0;
    int bad = 0;
    mem_stage_if bus();
    mem_stage #(.MAX_WAIT(15)) dut (
        .clk(clk), .rst_n(rst_n), .Result(Result), .mem_data_ex(mem_data_ex),
        .opcode_ex(opcode_ex), .MemWrite_ex(MemWrite_ex), .MemtoReg_ex(MemtoReg_ex),
        .RegWrite_ex(RegWrite_ex), .towrite_ex(towrite_ex), .bus(bus.master),
        .result_mem(result_mem), .towrite_mem(towrite_mem), .RegWrite_mem(RegWrite_mem),
        .mem_stall(mem_stall), .mem_error(mem_error)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic nop();
        MemtoReg_ex = 1'b0;
        MemWrite_ex = 1'b0;
        RegWrite_ex = 1'b0;
        opcode_ex = 6'h00;
        bus.dmem_ack = 1'b0;
    endtask
    task automatic do_load(input string tag, input logic [5:0] op, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [3:0] be, input logic [31:0] exp);
        opcode_ex = op; Result = addr; MemtoReg_ex = 1'b1; MemWrite_ex = 1'b0;
        RegWrite_ex = 1'b1; towrite_ex = 5'd9; bus.dmem_rdata = rdata; bus.dmem_ack = 1'b0;
        #2 chk({tag, "_stall_idle"}, mem_stall, 1);
        tick();
        chk({tag, "_req"}, bus.dmem_req, 1);
        chk({tag, "_be"}, bus.dmem_be, be);
        bus.dmem_ack = 1'b1;
        #2 chk({tag, "_stall_ack"}, mem_stall, 0);
        tick();
        nop();
        chk({tag, "_data"}, result_mem, exp);
        chk({tag, "_rw"}, RegWrite_mem, 1);
    endtask
    initial begin
        int n;
        logic last_stall;
        rst_n = 1'b0;
        Result = '0; mem_data_ex = '0; towrite_ex = '0; bus.dmem_rdata = '0;
        nop();
        #2;
        chk("rst_result", result_mem, 0);
        chk("rst_rw", RegWrite_mem, 0);
        chk("rst_req", bus.dmem_req, 0);
        chk("rst_stall", mem_stall, 0);
        chk("rst_err", mem_error, 0);
        tick(); tick();
        rst_n = 1'b1;
        // ALU pass-through
        Result = 32'h0000_1234; RegWrite_ex = 1'b1; towrite_ex = 5'd5;
        #2 chk("add_stall", mem_stall, 0);
        tick();
        chk("add_result", result_mem, 32'h1234);
        chk("add_towrite", towrite_mem, 5);
        chk("add_rw", RegWrite_mem, 1);
        chk("add_req", bus.dmem_req, 0);
        // lb with ack two cycles after request
        opcode_ex = 6'h20; Result = 32'h103; MemtoReg_ex = 1'b1; towrite_ex = 5'd7;
        bus.dmem_rdata = 32'h1122_3380;
        #2 chk("lb_stall0", mem_stall, 1);
        chk("lb_req_idle", bus.dmem_req, 0);
        tick();
        chk("lb_req", bus.dmem_req, 1);
        chk("lb_we", bus.dmem_we, 0);
        chk("lb_be", bus.dmem_be, 4'b0001);
        chk("lb_addr", bus.dmem_addr, 30'h40);
        chk("lb_stall1", mem_stall, 1);
        chk("lb_bubble", RegWrite_mem, 0);
        tick();
        chk("lb_stall2", mem_stall, 1);
        bus.dmem_ack = 1'b1;
        #2 chk("lb_stall_ack", mem_stall, 0);
        tick();
        nop();
        chk("lb_data", result_mem, 32'hFFFF_FF80);
        chk("lb_rw", RegWrite_mem, 1);
        chk("lb_towrite", towrite_mem, 7);
        chk("lb_req_done", bus.dmem_req, 0);
        // sh store
        opcode_ex = 6'h29; Result = 32'h202; mem_data_ex = 32'h0000_ABCD; MemWrite_ex = 1'b1;
        #2 chk("sh_stall", mem_stall, 1);
        tick();
        chk("sh_we", bus.dmem_we, 1);
        chk("sh_be", bus.dmem_be, 4'b0011);
        chk("sh_wdata", bus.dmem_wdata, 32'hABCD_ABCD);
        bus.dmem_ack = 1'b1;
        tick();
        nop();
        chk("sh_rw", RegWrite_mem, 0);
        chk("sh_result", result_mem, 32'h202);
        chk("sh_err", mem_error, 0);
        // Remaining load widths and signedness
        do_load("lh", 6'h21, 32'h300, 32'h8001_1234, 4'b1100, 32'hFFFF_8001);
        do_load("lhu", 6'h25, 32'h302, 32'h1122_F0AB, 4'b0011, 32'h0000_F0AB);
        do_load("lbu", 6'h24, 32'h101, 32'h11A5_3344, 4'b0100, 32'h0000_00A5);
        do_load("lbp", 6'h20, 32'h100, 32'h7F00_0000, 4'b1000, 32'h0000_007F);
        do_load("lw", 6'h23, 32'h104, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
        // ack while idle must be ignored
        Result = 32'h55; RegWrite_ex = 1'b1; towrite_ex = 5'd3; bus.dmem_ack = 1'b1;
        #2 chk("idle_ack_req", bus.dmem_req, 0);
        tick();
        nop();
        chk("idle_ack_result", result_mem, 32'h55);
        chk("idle_ack_rw", RegWrite_mem, 1);
        // misaligned lw
        opcode_ex = 6'h23; Result = 32'h101; MemtoReg_ex = 1'b1; RegWrite_ex = 1'b1;
        #2 chk("mis_stall", mem_stall, 0);
        chk("mis_req", bus.dmem_req, 0);
        tick();
        nop();
        chk("mis_err", mem_error, 1);
        chk("mis_rw", RegWrite_mem, 0);
        chk("mis_req2", bus.dmem_req, 0);
        tick();
        chk("err_sticky", mem_error, 1);
        rst_n = 1'b0;
        #2 chk("err_rst", mem_error, 0);
        tick();
        rst_n = 1'b1;
        // sw timeout
        opcode_ex = 6'h2B; Result = 32'h400; mem_data_ex = 32'h1234_5678; MemWrite_ex = 1'b1;
        #2;
        tick();
        chk("sw_be", bus.dmem_be, 4'b1111);
        chk("sw_wdata", bus.dmem_wdata, 32'h1234_5678);
        n = 0;
        last_stall = 1'b1;
        while (bus.dmem_req && n < 40) begin
            last_stall = mem_stall;
            n++;
            tick();
        end
        chk("to_cycles", n, 15);
        chk("to_last_stall", last_stall, 0);
        chk("to_req", bus.dmem_req, 0);
        chk("to_err", mem_error, 1);
        chk("to_rw", RegWrite_mem, 0);
        nop();
        tick();
        // async reset in the middle of an access
        opcode_ex = 6'h2B; Result = 32'h500; MemWrite_ex = 1'b1;
        #2;
        tick();
        chk("ra_req", bus.dmem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ra_req_off", bus.dmem_req, 0);
        chk("ra_stall", mem_stall, 0);
        chk("ra_err", mem_error, 0);
        chk("ra_result", result_mem, 0);
        chk("ra_towrite", towrite_mem, 0);
        chk("ra_rw", RegWrite_mem, 0);
        nop();
        tick();
        rst_n = 1'b1;
        tick();
        chk("ra_no_replay", bus.dmem_req, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
